// File: rtl/rrf_commit_map_if.sv
// ----------------------------------------------------------------------------
// rrf_commit_map_if
// Bundles every non-clock/reset signal of the retirement rename table.
//   commit side  : cm_valid/cm_ready handshake carrying cm_has_dest, cm_rd, cm_prd
//   free side    : fr_valid/fr_ready handshake carrying fr_prd, plus fr_count
//   recovery     : flush_req in, restore_en strobe and restore_tab (full map) out
//   debug lookup : q_rd in, q_prd out
// Modports: master = ROB / free list / frf side, slave = rrf_commit_map.
// ----------------------------------------------------------------------------
interface rrf_commit_map_if #(
   parameter int ARCH   = 32,
   parameter int PHYS   = 64,
   parameter int AW     = $clog2(ARCH),
   parameter int PW     = $clog2(PHYS),
   parameter int FDEPTH = 4
);
   logic                          cm_valid;
   logic                          cm_ready;
   logic                          cm_has_dest;
   logic [AW-1:0]                 cm_rd;
   logic [PW-1:0]                 cm_prd;
   logic                          fr_valid;
   logic                          fr_ready;
   logic [PW-1:0]                 fr_prd;
   logic [$clog2(FDEPTH):0]       fr_count;
   logic                          flush_req;
   logic                          restore_en;
   logic [ARCH-1:0][PW-1:0]       restore_tab;
   logic [AW-1:0]                 q_rd;
   logic [PW-1:0]                 q_prd;

   modport master (
      output cm_valid, cm_has_dest, cm_rd, cm_prd, fr_ready, flush_req, q_rd,
      input  cm_ready, fr_valid, fr_prd, fr_count, restore_en, restore_tab, q_prd
   );

   modport slave (
      input  cm_valid, cm_has_dest, cm_rd, cm_prd, fr_ready, flush_req, q_rd,
      output cm_ready, fr_valid, fr_prd, fr_count, restore_en, restore_tab, q_prd
   );
endinterface

// File: rtl/rrf_commit_map.sv
// ----------------------------------------------------------------------------
// rrf_commit_map
// Retirement rename table. Holds the committed arch->phys map, updated in
// program order by ROB commits. Each commit with a destination pushes the
// displaced physical register into a small freed-reg FIFO feeding the free
// list. A flush triggers a one-cycle restore strobe while restore_tab (always
// the committed map) is copied into the speculative rename table.
//
// Ports
//   clk     : clock, all state on posedge
//   rst_n   : asynchronous active-low reset
//   bus     : rrf_commit_map_if.slave
//             cm_*       commit handshake from ROB
//             fr_*       freed-reg handshake to free list, fr_count occupancy
//             flush_req  recovery pulse; restore_en/restore_tab to frf
//             q_rd/q_prd combinational committed-map lookup
//
// Configuration
//   RRF_X0_HARDWIRE_EN : arch reg 0 is hardwired to phys 0. A commit to rd 0
//                        leaves the map alone and frees its own cm_prd;
//                        lookups and restore_tab[0] read 0.
//                        Undefined: reg 0 behaves like any other register.
// ----------------------------------------------------------------------------
module rrf_commit_map #(
   parameter int ARCH   = 32,
   parameter int PHYS   = 64,
   parameter int AW     = $clog2(ARCH),
   parameter int PW     = $clog2(PHYS),
   parameter int FDEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   rrf_commit_map_if.slave   bus
);

   localparam int FAW = $clog2(FDEPTH);
   localparam int CW  = FAW + 1;

   typedef enum logic {
      IDLE    = 1'b0,
      RESTORE = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic                      restore_en_q, restore_en_d;
   logic [ARCH-1:0][PW-1:0]   rmap_q, rmap_d;
   logic [FDEPTH-1:0][PW-1:0] mem_q, mem_d;
   logic [FAW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [FAW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             count_q, count_d;

   logic                      fr_valid;
   logic                      pop;
   logic                      cm_ready;
   logic                      push;
   logic [PW-1:0]             push_prd;
   logic [PW-1:0]             q_prd;

   always_comb begin
      fr_valid = (count_q != '0);
      pop      = fr_valid & bus.fr_ready;
      // A full FIFO still takes a commit when the head leaves this cycle.
      // rst_n gating keeps the commit port closed while reset is held.
      cm_ready = rst_n & (state_q == IDLE) & ~bus.flush_req &
                 ((count_q < CW'(FDEPTH)) | pop);
      push     = bus.cm_valid & cm_ready & bus.cm_has_dest;

      rmap_d   = rmap_q;
`ifdef RRF_X0_HARDWIRE_EN
      if (bus.cm_rd == '0) begin
         // rd 0 never holds a mapping, so the newly allocated reg is dead at once.
         push_prd = bus.cm_prd;
      end else begin
         push_prd = rmap_q[bus.cm_rd];
         if (push) rmap_d[bus.cm_rd] = bus.cm_prd;
      end
`else
      push_prd = rmap_q[bus.cm_rd];
      if (push) rmap_d[bus.cm_rd] = bus.cm_prd;
`endif

      // No bypass: a push into an empty FIFO is visible at the head next cycle.
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_prd;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Restore lasts exactly one cycle; a flush seen in RESTORE is dropped.
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.flush_req) state_d = RESTORE;
         RESTORE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      restore_en_d = (state_d == RESTORE);

`ifdef RRF_X0_HARDWIRE_EN
      q_prd = (bus.q_rd == '0) ? '0 : rmap_q[bus.q_rd];
`else
      q_prd = rmap_q[bus.q_rd];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         restore_en_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < ARCH; i++) rmap_q[i] <= PW'(i);
      end else begin
         state_q      <= state_d;
         restore_en_q <= restore_en_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rmap_q       <= rmap_d;
      end
   end

   // FIFO storage needs no reset: fr_prd is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.cm_ready    = cm_ready;
   assign bus.fr_valid    = fr_valid;
   assign bus.fr_prd      = fr_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.fr_count    = count_q;
   assign bus.restore_en  = restore_en_q;
   assign bus.restore_tab = rmap_q;
   assign bus.q_prd       = q_prd;

endmodule

// File: tb/tb_rrf_commit_map.sv
module tb_rrf_commit_map;

   localparam int ARCH   = 32;
   localparam int PHYS   = 64;
   localparam int AW     = 5;
   localparam int PW     = 6;
   localparam int FDEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rrf_commit_map_if #(.ARCH(ARCH), .PHYS(PHYS), .AW(AW), .PW(PW), .FDEPTH(FDEPTH)) bus ();

   rrf_commit_map #(.ARCH(ARCH), .PHYS(PHYS), .AW(AW), .PW(PW), .FDEPTH(FDEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [PW-1:0] model [ARCH];
   logic [PW-1:0] exp_q [$];
   logic [PW-1:0] act_q [$];

   task automatic reset_model();
      for (int i = 0; i < ARCH; i++) model[i] = PW'(i);
      exp_q.delete();
      act_q.delete();
   endtask

   // Advance one cycle; record accepted commits into the scoreboard model
   // and capture every freed register actually handed to the free list.
   task automatic tick();
      @(negedge clk);
      if (bus.fr_valid && bus.fr_ready) act_q.push_back(bus.fr_prd);
      if (bus.cm_valid && bus.cm_ready && bus.cm_has_dest) begin
`ifdef RRF_X0_HARDWIRE_EN
         if (bus.cm_rd == '0) exp_q.push_back(bus.cm_prd);
         else begin
            exp_q.push_back(model[bus.cm_rd]);
            model[bus.cm_rd] = bus.cm_prd;
         end
`else
         exp_q.push_back(model[bus.cm_rd]);
         model[bus.cm_rd] = bus.cm_prd;
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_commit(input logic v, input logic [AW-1:0] rd, input logic [PW-1:0] prd);
      bus.cm_valid    = v;
      bus.cm_has_dest = 1'b1;
      bus.cm_rd       = rd;
      bus.cm_prd      = prd;
   endtask

   task automatic test_reset();
      bus.cm_valid = 0; bus.cm_has_dest = 0; bus.cm_rd = '0; bus.cm_prd = '0;
      bus.fr_ready = 0; bus.flush_req = 0; bus.q_rd = '0;
      rst_n = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.restore_en !== 1'b0) begin failures++; $display("FAIL rst_restore_en got=%0b want=0", bus.restore_en); end
      checks++; if (bus.fr_valid !== 1'b0) begin failures++; $display("FAIL rst_fr_valid got=%0b want=0", bus.fr_valid); end
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL rst_fr_count got=%0d want=0", bus.fr_count); end
      checks++; if (bus.fr_prd !== 6'd0) begin failures++; $display("FAIL rst_fr_prd got=%0d want=0", bus.fr_prd); end
      checks++; if (bus.cm_ready !== 1'b0) begin failures++; $display("FAIL rst_cm_ready got=%0b want=0", bus.cm_ready); end
      for (int i = 0; i < ARCH; i++) begin
         bus.q_rd = AW'(i);
         #1;
         checks++; if (bus.q_prd !== PW'(i)) begin failures++; $display("FAIL rst_q_prd[%0d] got=%0d want=%0d", i, bus.q_prd, i); end
         checks++; if (bus.restore_tab[i] !== PW'(i)) begin failures++; $display("FAIL rst_restore_tab[%0d] got=%0d want=%0d", i, bus.restore_tab[i], i); end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL post_rst_cm_ready got=%0b want=1", bus.cm_ready); end
   endtask

   task automatic test_single_commit();
      bus.fr_ready = 1'b1;
      set_commit(1'b1, 5'd5, 6'd40);
      #1;
      checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL single_cm_ready got=%0b want=1", bus.cm_ready); end
      tick();
      bus.cm_valid = 1'b0;
      bus.q_rd = 5'd5;
      #1;
      checks++; if (bus.q_prd !== 6'd40) begin failures++; $display("FAIL single_q_prd got=%0d want=40", bus.q_prd); end
      checks++; if (bus.fr_valid !== 1'b1) begin failures++; $display("FAIL single_fr_valid got=%0b want=1", bus.fr_valid); end
      checks++; if (bus.fr_prd !== 6'd5) begin failures++; $display("FAIL single_fr_prd got=%0d want=5", bus.fr_prd); end
      checks++; if (bus.fr_count !== 3'd1) begin failures++; $display("FAIL single_fr_count got=%0d want=1", bus.fr_count); end
      tick();
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL single_popped_count got=%0d want=0", bus.fr_count); end
      checks++; if (bus.fr_valid !== 1'b0) begin failures++; $display("FAIL single_popped_valid got=%0b want=0", bus.fr_valid); end
   endtask

   task automatic test_fifo_full();
      int n;
      bus.fr_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         set_commit(1'b1, AW'(i), PW'(32 + i));
         tick();
      end
      set_commit(1'b1, 5'd6, 6'd37);
      #1;
      checks++; if (bus.fr_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d want=4", bus.fr_count); end
      checks++; if (bus.cm_ready !== 1'b0) begin failures++; $display("FAIL full_cm_ready got=%0b want=0", bus.cm_ready); end
      tick();
      bus.fr_ready = 1'b1;
      #1;
      checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL full_pushpop_ready got=%0b want=1", bus.cm_ready); end
      tick();
      bus.cm_valid = 1'b0;
      bus.fr_ready = 1'b0;
      bus.q_rd = 5'd6;
      #1;
      checks++; if (bus.fr_count !== 3'd4) begin failures++; $display("FAIL full_pushpop_count got=%0d want=4", bus.fr_count); end
      checks++; if (bus.fr_prd !== 6'd2) begin failures++; $display("FAIL full_head got=%0d want=2", bus.fr_prd); end
      checks++; if (bus.q_prd !== 6'd37) begin failures++; $display("FAIL full_q_prd got=%0d want=37", bus.q_prd); end
      bus.fr_ready = 1'b1;
      n = 0;
      while (bus.fr_valid === 1'b1 && n < 16) begin tick(); n++; end
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL full_drain got=%0d want=0", bus.fr_count); end
   endtask

   task automatic test_back_to_back();
      int n;
      bus.fr_ready = 1'b0;
      set_commit(1'b1, 5'd7, 6'd50);
      tick();
      set_commit(1'b1, 5'd7, 6'd51);
      tick();
      bus.cm_valid = 1'b0;
      bus.q_rd = 5'd7;
      #1;
      checks++; if (bus.q_prd !== 6'd51) begin failures++; $display("FAIL b2b_q_prd got=%0d want=51", bus.q_prd); end
      checks++; if (bus.fr_count !== 3'd2) begin failures++; $display("FAIL b2b_count got=%0d want=2", bus.fr_count); end
      checks++; if (bus.fr_prd !== 6'd7) begin failures++; $display("FAIL b2b_first got=%0d want=7", bus.fr_prd); end
      bus.fr_ready = 1'b1;
      tick();
      checks++; if (bus.fr_prd !== 6'd50) begin failures++; $display("FAIL b2b_second got=%0d want=50", bus.fr_prd); end
      n = 0;
      while (bus.fr_valid === 1'b1 && n < 16) begin tick(); n++; end
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL b2b_drain got=%0d want=0", bus.fr_count); end
   endtask

   task automatic test_flush();
      int n;
      int bad;
      bus.fr_ready = 1'b0;
      set_commit(1'b1, 5'd9, 6'd60);
      tick();
      set_commit(1'b1, 5'd10, 6'd61);
      bus.flush_req = 1'b1;
      #1;
      checks++; if (bus.cm_ready !== 1'b0) begin failures++; $display("FAIL flush_cm_ready got=%0b want=0", bus.cm_ready); end
      checks++; if (bus.restore_en !== 1'b0) begin failures++; $display("FAIL flush_early_restore got=%0b want=0", bus.restore_en); end
      tick();
      // Now in RESTORE: hold flush_req high to confirm it is ignored.
      bus.fr_ready = 1'b1;
      #1;
      checks++; if (bus.restore_en !== 1'b1) begin failures++; $display("FAIL restore_en got=%0b want=1", bus.restore_en); end
      checks++; if (bus.cm_ready !== 1'b0) begin failures++; $display("FAIL restore_cm_ready got=%0b want=0", bus.cm_ready); end
      checks++; if (bus.fr_valid !== 1'b1) begin failures++; $display("FAIL restore_fr_valid got=%0b want=1", bus.fr_valid); end
      checks++; if (bus.restore_tab[9] !== 6'd60) begin failures++; $display("FAIL restore_tab9 got=%0d want=60", bus.restore_tab[9]); end
      checks++; if (bus.restore_tab[10] !== 6'd10) begin failures++; $display("FAIL restore_tab10 got=%0d want=10", bus.restore_tab[10]); end
      bad = 0;
      for (int i = 0; i < ARCH; i++) if (bus.restore_tab[i] !== model[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL restore_tab_model mismatched_entries=%0d want=0", bad); end
      tick();
      bus.flush_req = 1'b0;
      #1;
      checks++; if (bus.restore_en !== 1'b0) begin failures++; $display("FAIL restore_one_cycle got=%0b want=0", bus.restore_en); end
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL restore_drained got=%0d want=0", bus.fr_count); end
      checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL after_restore_ready got=%0b want=1", bus.cm_ready); end
      tick();
      bus.cm_valid = 1'b0;
      bus.q_rd = 5'd10;
      #1;
      checks++; if (bus.restore_en !== 1'b0) begin failures++; $display("FAIL second_flush_ignored got=%0b want=0", bus.restore_en); end
      checks++; if (bus.q_prd !== 6'd61) begin failures++; $display("FAIL after_restore_q_prd got=%0d want=61", bus.q_prd); end
      n = 0;
      while (bus.fr_valid === 1'b1 && n < 16) begin tick(); n++; end
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL flush_drain got=%0d want=0", bus.fr_count); end
   endtask

   task automatic test_rd0();
      int n;
      bus.fr_ready = 1'b0;
      set_commit(1'b1, 5'd0, 6'd45);
      tick();
      bus.cm_valid = 1'b0;
      bus.q_rd = 5'd0;
      #1;
`ifdef RRF_X0_HARDWIRE_EN
      checks++; if (bus.q_prd !== 6'd0) begin failures++; $display("FAIL x0_q_prd got=%0d want=0", bus.q_prd); end
      checks++; if (bus.fr_prd !== 6'd45) begin failures++; $display("FAIL x0_fr_prd got=%0d want=45", bus.fr_prd); end
      checks++; if (bus.restore_tab[0] !== 6'd0) begin failures++; $display("FAIL x0_restore_tab got=%0d want=0", bus.restore_tab[0]); end
`else
      checks++; if (bus.q_prd !== 6'd45) begin failures++; $display("FAIL rd0_q_prd got=%0d want=45", bus.q_prd); end
      checks++; if (bus.fr_prd !== 6'd0) begin failures++; $display("FAIL rd0_fr_prd got=%0d want=0", bus.fr_prd); end
      checks++; if (bus.restore_tab[0] !== 6'd45) begin failures++; $display("FAIL rd0_restore_tab got=%0d want=45", bus.restore_tab[0]); end
`endif
      bus.fr_ready = 1'b1;
      n = 0;
      while (bus.fr_valid === 1'b1 && n < 16) begin tick(); n++; end
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL rd0_drain got=%0d want=0", bus.fr_count); end
   endtask

   task automatic test_freed_order();
      logic [PW-1:0] golden [11];
      logic [PW-1:0] a, e;
      golden = '{6'd5, 6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd50, 6'd9, 6'd10, 6'd0};
`ifdef RRF_X0_HARDWIRE_EN
      golden[10] = 6'd45;
`endif
      checks++; if (act_q.size() != 11) begin failures++; $display("FAIL freed_total got=%0d want=11", act_q.size()); end
      checks++; if (exp_q.size() != act_q.size()) begin failures++; $display("FAIL sb_size got=%0d want=%0d", act_q.size(), exp_q.size()); end
      for (int i = 0; i < 11 && act_q.size() > 0; i++) begin
         a = act_q.pop_front();
         checks++; if (a !== golden[i]) begin failures++; $display("FAIL freed_seq[%0d] got=%0d want=%0d", i, a, golden[i]); end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (a !== e) begin failures++; $display("FAIL sb_freed[%0d] got=%0d want=%0d", i, a, e); end
         end
      end
   endtask

   task automatic test_reset_mid_restore();
      bus.fr_ready = 1'b0;
      set_commit(1'b1, 5'd3, 6'd20);
      tick();
      bus.cm_valid = 1'b0;
      bus.flush_req = 1'b1;
      tick();
      bus.flush_req = 1'b0;
      bus.q_rd = 5'd3;
      #1;
      checks++; if (bus.restore_en !== 1'b1) begin failures++; $display("FAIL mid_restore_en got=%0b want=1", bus.restore_en); end
      checks++; if (bus.q_prd !== 6'd20) begin failures++; $display("FAIL mid_q_prd got=%0d want=20", bus.q_prd); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.restore_en !== 1'b0) begin failures++; $display("FAIL mid_rst_restore_en got=%0b want=0", bus.restore_en); end
      checks++; if (bus.fr_count !== 3'd0) begin failures++; $display("FAIL mid_rst_count got=%0d want=0", bus.fr_count); end
      checks++; if (bus.fr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_fr_valid got=%0b want=0", bus.fr_valid); end
      checks++; if (bus.q_prd !== 6'd3) begin failures++; $display("FAIL mid_rst_q_prd got=%0d want=3", bus.q_prd); end
      reset_model();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.restore_en !== 1'b0) begin failures++; $display("FAIL post_mid_restore_en got=%0b want=0", bus.restore_en); end
      checks++; if (bus.cm_ready !== 1'b1) begin failures++; $display("FAIL post_mid_cm_ready got=%0b want=1", bus.cm_ready); end
   endtask

   initial begin
      test_reset();
      test_single_commit();
      test_fifo_full();
      test_back_to_back();
      test_flush();
      test_rd0();
      test_freed_order();
      test_reset_mid_restore();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

endmodule
